alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one combinational 32-bit ALU (4-bit op code; flags O, C, Z, N) between NUM_REQ requesters. Each requester uses a valid/ready request channel. The block picks a round-robin winner, latches its operands, drives the ALU for one execute cycle, registers result and flags, and returns them on a valid/ready response channel tagged with the winner's index. It sits between the issue logic and the shared ALU instance.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 32, operand/result width; must match the ALU
OP_W, 4, op-code width; must match the ALU
ID_W, $clog2(NUM_REQ) (min 1), width of the requester index

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_a  in  NUM_REQ*DATA_W  operand A; requester i occupies slice i
req_b  in  NUM_REQ*DATA_W  operand B, same packing
req_op  in  NUM_REQ*OP_W  op code, same packing
alu_a  out  DATA_W  registered operand A to the ALU
alu_b  out  DATA_W  registered operand B to the ALU
alu_op  out  OP_W  registered op code to the ALU
alu_y  in  DATA_W  ALU result
alu_flags  in  4  ALU flags {O,C,Z,N}
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_y  out  DATA_W  registered result
rsp_flags  out  4  registered {O,C,Z,N}
rsp_id  out  ID_W  index of the requester served
rsp_illegal  out  1  op code was outside 0..6; result forced 0
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all outputs 0; rr_ptr=0; operand and result registers 0.
- FSM states: IDLE, EXEC, RESP. Transition IDLE->EXEC->RESP->IDLE.
- IDLE:
  - If any req_valid is set, grant the first valid index searching from rr_ptr upward with wrap-around.
  - req_ready[winner]=1 for that cycle only; combinational from req_valid and rr_ptr; no other bit set.
  - Handshake = req_valid & req_ready. On that edge, latch the winner's a/b/op into alu_a/alu_b/alu_op, store the winner index, move to EXEC.
  - If no req_valid is set, stay in IDLE; req_ready=0.
- EXEC:
  - One cycle. ALU inputs are stable from the registers.
  - On the clock edge, capture rsp_y=alu_y and rsp_flags=alu_flags.
  - rsp_illegal=(alu_op>6). If illegal, force rsp_y=0 and rsp_flags={0,0,1,0} (Z only), independent of ALU output.
  - Move to RESP.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_valid & rsp_ready: go to IDLE and set rr_ptr=(winner+1) mod NUM_REQ.
  - No new grant in the same cycle; the next grant is at the earliest in the following IDLE cycle.
- Latency: request handshake at edge T -> rsp_valid high from T+2. Peak throughput: 1 op per 3 cycles.
- req_ready is 0 in EXEC and RESP. Requesters must hold valid and data until accepted; a request withdrawn before grant is simply not served.
- Fairness: a continuously valid requester is served within NUM_REQ grants.
- Simultaneous requests: the lowest index at or after rr_ptr wins. Example: NUM_REQ=2, rr_ptr=0, both valid -> 0 wins, then 1.
- alu_a/alu_b/alu_op are not cleared after an op; they hold their last values.
- Reset mid-operation: state returns to IDLE immediately; an in-flight response is dropped (rsp_valid falls asynchronously); rr_ptr=0.
- Flags are passed through unmodified for legal ops; no recomputation.

Decomposition:
- Package alu_ctrl_pkg holds:
  - localparam op codes: OP_ADD=0, OP_SUB=1, OP_INC=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_NOT=6, OP_MAX_LEGAL=6
  - typedef enum state_t {IDLE, EXEC, RESP}
  - typedef struct packed alu_flags_t {o, c, z, n}
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr; outputs one-hot grant and index. Purely combinational; the pointer register stays in alu_arbiter.

Test Plan:
- Single op: req 0 valid, a=5, b=3, op=0; after handshake at T -> at T+2: rsp_valid=1, rsp_y=8, rsp_id=0, flags={0,0,0,0}, busy=1 during T+1..T+2.
- Round-robin contention: req 0 and 1 both held valid with op=1, (10,4) and (4,10) -> responses in order id0 (y=6), id1 (y=0xFFFFFFFA, N=1), id0, id1; never two consecutive grants to the same requester.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_y, rsp_id stable and req_ready all 0 throughout; one cycle after rsp_ready=1, busy=0.
- Illegal op: op=9, a=b=0xFFFF -> rsp_illegal=1, rsp_y=0, flags={0,0,1,0}. Next legal op (op=2, a=0xFFFFFFFF) -> rsp_illegal=0, rsp_y=0, Z=1, C=1.
- Reset mid-op: assert rst_n=0 during EXEC -> rsp_valid=0, busy=0, req_ready=0 asynchronously. After release, with both requesters valid, requester 0 is granted first (rr_ptr=0).
- No requests: all req_valid=0 for 10 cycles -> state IDLE, req_ready=0, rsp_valid=0, alu_* unchanged.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// alu_ctrl_pkg : op codes, FSM states and flag layout for the shared-ALU arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

  localparam int OP_ADD       = 0;
  localparam int OP_SUB       = 1;
  localparam int OP_INC       = 2;
  localparam int OP_AND       = 3;
  localparam int OP_OR        = 4;
  localparam int OP_XOR       = 5;
  localparam int OP_NOT       = 6;
  localparam int OP_MAX_LEGAL = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic o;
    logic c;
    logic z;
    logic n;
  } alu_flags_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick, first request at or after ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N    = 2,
  parameter int ID_W = 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx
);

  logic w_found;

  // Walk offsets 0..N-1 from ptr; the first requesting slot wins.
  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!w_found && req[k] && (k == (int'(ptr) + i) % N)) begin
          grant[k] = 1'b1;
          idx      = ID_W'(k);
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : round-robin sharing of one combinational ALU among requesters
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_op,
  input  logic [DATA_W-1:0]         alu_y,
  input  logic [3:0]                alu_flags,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_y,
  output logic [3:0]                rsp_flags,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_illegal,
  output logic                      busy
);

  state_t              r_state, w_next;
  logic [ID_W-1:0]     r_ptr, r_id, w_idx;
  logic [NUM_REQ-1:0]  w_grant;
  logic [DATA_W-1:0]   w_sel_a, w_sel_b, r_alu_a, r_alu_b, r_rsp_y;
  logic [OP_W-1:0]     w_sel_op, r_alu_op;
  alu_flags_t          r_flags;
  logic                r_illegal, w_hs, w_illegal;

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx)
  );

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_sel_a  = req_a[k*DATA_W +: DATA_W];
        w_sel_b  = req_b[k*DATA_W +: DATA_W];
        w_sel_op = req_op[k*OP_W +: OP_W];
      end
    end
  end

  assign w_hs      = (r_state == IDLE) && (|req_valid);
  assign w_illegal = r_alu_op > OP_W'(OP_MAX_LEGAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|req_valid) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_id      <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_rsp_y   <= '0;
      r_flags   <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_hs) begin
        r_alu_a  <= w_sel_a;
        r_alu_b  <= w_sel_b;
        r_alu_op <= w_sel_op;
        r_id     <= w_idx;
      end
      // Illegal ops ignore whatever the ALU produced and report a clean zero.
      if (r_state == EXEC) begin
        r_illegal <= w_illegal;
        r_rsp_y   <= w_illegal ? '0 : alu_y;
        r_flags   <= w_illegal ? '{o: 1'b0, c: 1'b0, z: 1'b1, n: 1'b0}
                               : alu_flags_t'(alu_flags);
      end
      if ((r_state == RESP) && rsp_ready)
        r_ptr <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
    end
  end

  // rst_n gating keeps req_ready low while reset is held, even with valid high.
  assign req_ready   = ((r_state == IDLE) && rst_n) ? w_grant : '0;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign rsp_valid   = (r_state == RESP);
  assign rsp_y       = r_rsp_y;
  assign rsp_flags   = r_flags;
  assign rsp_id      = r_id;
  assign rsp_illegal = r_illegal;
  assign busy        = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// tb_alu_arbiter : directed vector table plus multi-cycle sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam int IW = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a = '0, req_b = '0;
  logic [N*OW-1:0] req_op = '0;
  logic [DW-1:0]   alu_a, alu_b, alu_y, rsp_y;
  logic [OW-1:0]   alu_op;
  logic [3:0]      alu_flags, rsp_flags;
  logic            rsp_valid, rsp_ready = 1'b0, rsp_illegal, busy;
  logic [IW-1:0]   rsp_id;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_id(rsp_id),
    .rsp_illegal(rsp_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU; flags {O,C,Z,N}, C on SUB means borrow. Illegal ops emit junk.
  logic [32:0] m_s;
  always_comb begin
    m_s       = '0;
    alu_y     = '0;
    alu_flags = '0;
    case (alu_op)
      4'd0: begin
        m_s = {1'b0, alu_a} + {1'b0, alu_b};
        alu_y = m_s[31:0];
        alu_flags[2] = m_s[32];
        alu_flags[3] = (alu_a[31] == alu_b[31]) && (alu_y[31] != alu_a[31]);
      end
      4'd1: begin
        alu_y = alu_a - alu_b;
        alu_flags[2] = alu_a < alu_b;
        alu_flags[3] = (alu_a[31] != alu_b[31]) && (alu_y[31] != alu_a[31]);
      end
      4'd2: begin
        m_s = {1'b0, alu_a} + 33'd1;
        alu_y = m_s[31:0];
        alu_flags[2] = m_s[32];
        alu_flags[3] = !alu_a[31] && alu_y[31];
      end
      4'd3: alu_y = alu_a & alu_b;
      4'd4: alu_y = alu_a | alu_b;
      4'd5: alu_y = alu_a ^ alu_b;
      4'd6: alu_y = ~alu_a;
      default: alu_y = 32'hDEADBEEF;
    endcase
    if (alu_op <= 4'd6) begin
      alu_flags[1] = (alu_y == 32'd0);
      alu_flags[0] = alu_y[31];
    end else begin
      alu_flags = 4'hF;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    req_a[id*DW +: DW]  = a;
    req_b[id*DW +: DW]  = b;
    req_op[id*OW +: OW] = op;
  endtask

  // Called at a negedge with the DUT idle; stall holds off rsp_ready.
  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [31:0] ey, input logic [3:0] ef,
                        input logic eill, input int stall);
    logic [31:0] held_y;
    req_valid = '0;
    set_req(id, a, b, op);
    req_valid[id] = 1'b1;
    #1;
    chk("grant", 32'(req_ready), 32'(1 << id));
    @(negedge clk);
    req_valid = '0;
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("alu_a_latched", alu_a, a);
    chk("alu_op_latched", 32'(alu_op), 32'(op));
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_y", rsp_y, ey);
    chk("rsp_flags", 32'(rsp_flags), 32'(ef));
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("rsp_illegal", 32'(rsp_illegal), 32'(eill));
    held_y = rsp_y;
    for (int s = 0; s < stall; s++) begin
      req_valid = '1;
      @(negedge clk);
      #1;
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_y", rsp_y, held_y);
      chk("stall_id", 32'(rsp_id), 32'(id));
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] y;
    logic [3:0]  f;
    logic        ill;
  } vec_t;

  vec_t vt[14];

  initial begin
    int          got;
    logic [31:0] hold_a;

    vt[0]  = '{0, 32'd5,        32'd3,        4'd0,  32'd8,        4'b0000, 1'b0};
    vt[1]  = '{1, 32'd10,       32'd4,        4'd1,  32'd6,        4'b0000, 1'b0};
    vt[2]  = '{0, 32'd4,        32'd10,       4'd1,  32'hFFFFFFFA, 4'b0101, 1'b0};
    vt[3]  = '{1, 32'h7FFFFFFF, 32'd1,        4'd0,  32'h80000000, 4'b1001, 1'b0};
    vt[4]  = '{0, 32'hFFFFFFFF, 32'd1,        4'd0,  32'd0,        4'b0110, 1'b0};
    vt[5]  = '{1, 32'hF0F0F0F0, 32'hFF00FF00, 4'd3,  32'hF000F000, 4'b0001, 1'b0};
    vt[6]  = '{0, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'd4,  32'hFFFFFFFF, 4'b0001, 1'b0};
    vt[7]  = '{1, 32'hAAAAAAAA, 32'hAAAAAAAA, 4'd5,  32'd0,        4'b0010, 1'b0};
    vt[8]  = '{0, 32'd0,        32'd123,      4'd6,  32'hFFFFFFFF, 4'b0001, 1'b0};
    vt[9]  = '{1, 32'h0000FFFF, 32'h0000FFFF, 4'd9,  32'd0,        4'b0010, 1'b1};
    vt[10] = '{0, 32'hFFFFFFFF, 32'd0,        4'd2,  32'd0,        4'b0110, 1'b0};
    vt[11] = '{1, 32'h7FFFFFFF, 32'd0,        4'd2,  32'h80000000, 4'b1001, 1'b0};
    vt[12] = '{0, 32'd1,        32'd2,        4'd15, 32'd0,        4'b0010, 1'b1};
    vt[13] = '{1, 32'd1,        32'd2,        4'd7,  32'd0,        4'b0010, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_rsp_y", rsp_y, 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++)
      run_op(vt[i].id, vt[i].a, vt[i].b, vt[i].op, vt[i].y, vt[i].f, vt[i].ill, 0);

    // Backpressure: response held for 5 cycles while the other requester waits.
    run_op(0, 32'd100, 32'd23, 4'd0, 32'd123, 4'b0000, 1'b0, 5);
    @(negedge clk);
    chk("post_bp_busy", 32'(busy), 32'd0);

    // Serve id0 so the pointer moves to 1, then reset while id1 is executing.
    run_op(0, 32'd1, 32'd1, 4'd0, 32'd2, 4'b0000, 1'b0, 0);
    set_req(1, 32'd3, 32'd3, 4'd0);
    req_valid = 2'b10;
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);

    // Contention: both held valid from reset release; expect 0,1,0,1.
    set_req(0, 32'd10, 32'd4, 4'd1);
    set_req(1, 32'd4, 32'd10, 4'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rr_first_grant", 32'(req_ready), 32'b01);
    rsp_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("rr_id", 32'(rsp_id), 32'(got % 2));
        chk("rr_y", rsp_y, (got % 2 == 0) ? 32'd6 : 32'hFFFFFFFA);
        chk("rr_flags", 32'(rsp_flags), (got % 2 == 0) ? 32'b0000 : 32'b0101);
        got++;
      end
    end
    req_valid = '0;
    chk("rr_count", 32'(got), 32'd4);
    @(negedge clk);
    rsp_ready = 1'b0;

    // Quiet period: nothing should move.
    hold_a = alu_a;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_req_ready", 32'(req_ready), 32'd0);
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("idle_alu_a", alu_a, hold_a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
